// File: rtl/pac_tx_framer_if.sv
// Payload-in / transmit-out bus of the packet framer.
// The framer connects through the master modport. A payload source and a line sink connect through the slave modport.
interface pac_tx_framer_if;
  logic [7:0] pld_data;
  logic       pld_vld;
  logic       pld_rdy;
  logic [7:0] txd;
  logic       tx_en;
  logic       pac_stp;

  modport master (
    input  pld_data, pld_vld,
    output pld_rdy, txd, tx_en, pac_stp
  );

  modport slave (
    output pld_data, pld_vld,
    input  pld_rdy, txd, tx_en, pac_stp
  );
endinterface

// File: rtl/pac_tx_framer.sv
// Transmitter packet framer.
// Each accepted ovp pulse starts a burst of up to PAC_NUM packets.
// Packet layout: SYNC, num[7:0], {5'b0,num[10:8]}, PLD_LEN payload bytes, then GAP_CYC idle cycles.
// txd, tx_en and pac_stp are registered from the next state, so a byte is on the line in the cycle after its state is decided.
module pac_tx_framer #(
  parameter int unsigned PLD_LEN = 256,
  parameter int unsigned GAP_CYC = 16,
  parameter int unsigned PAC_NUM = 1040,
  parameter logic [7:0]  SYNC    = 8'hFB,
  parameter logic [7:0]  FILL    = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ovp,
  input  logic                  enable,
  pac_tx_framer_if.master       bus,
  output logic [10:0]           pac_num,
  output logic                  frame_done,
  output logic                  underrun_err,
  output logic                  ovp_abort
);

  localparam int unsigned BW = (PLD_LEN < 2) ? 1 : $clog2(PLD_LEN + 1);
  localparam int unsigned GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);
  localparam logic [10:0] LAST_NUM = 11'(PAC_NUM - 1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, PLD, GAP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [10:0]   num_q, num_d;
  logic [7:0]    txd_q, txd_d;
  logic          en_q, en_d;
  logic          stp_q, stp_d;
  logic          done_q, done_d;
  logic          under_q, under_d;
  logic          abort_q, abort_d;
  logic          rdy;
  logic          clr;
  logic [1:0]    rst_sync_q;
  logic          rst_int_n;

  // Reset synchronizer: assertion is asynchronous, release is aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // State register and registered line outputs.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      num_q   <= '0;
      txd_q   <= '0;
      en_q    <= 1'b0;
      stp_q   <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      num_q   <= num_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      stp_q   <= stp_d;
      done_q  <= done_d;
      under_q <= under_d;
      abort_q <= abort_d;
    end
  end

  // Next-state, counters, and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    num_d   = num_q;
    txd_d   = '0;
    en_d    = 1'b0;
    stp_d   = 1'b0;
    rdy     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ovp && enable) begin
          state_d = HDR0;
          num_d   = '0;
        end
      end
      HDR0: state_d = HDR1;
      HDR1: state_d = HDR2;
      HDR2: begin
        state_d = PLD;
        bcnt_d  = BW'(1);
      end
      PLD: begin
        if (bcnt_q == BW'(PLD_LEN)) begin
          state_d = GAP;
          gcnt_d  = GW'(1);
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      GAP: begin
        if (gcnt_q == GW'(GAP_CYC)) begin
          if (enable && (num_q != LAST_NUM)) begin
            state_d = HDR0;
            num_d   = num_q + 11'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // ovp outside IDLE overrides the normal transition.
    // With enable high it restarts at packet 0.
    // With enable low it stops the burst and pac_num is held.
    if (ovp && (state_q != IDLE)) begin
      if (enable) begin
        state_d = HDR0;
        num_d   = '0;
      end else begin
        state_d = IDLE;
      end
    end

    // Line byte is chosen by the state entered at this edge.
    case (state_d)
      HDR0:    txd_d = SYNC;
      HDR1:    txd_d = num_d[7:0];
      HDR2:    txd_d = {5'b0, num_d[10:8]};
      PLD:     txd_d = bus.pld_vld ? bus.pld_data : FILL;
      default: txd_d = '0;
    endcase
    en_d  = (state_d == HDR0) || (state_d == HDR1) || (state_d == HDR2) || (state_d == PLD);
    rdy   = (state_d == PLD);
    stp_d = (state_d == PLD) && (bcnt_d == BW'(PLD_LEN));
  end

  // Frame-complete pulse and the sticky per-frame error flags.
  always_comb begin
    done_d  = stp_q && (num_q == LAST_NUM);
    clr     = ovp && ((state_q != IDLE) || enable);
    under_d = clr ? 1'b0 : under_q;
    abort_d = clr ? 1'b0 : abort_q;
    if (rdy && !bus.pld_vld) under_d = 1'b1;
    if (ovp && ((state_q == HDR0) || (state_q == HDR1) ||
                (state_q == HDR2) || (state_q == PLD))) abort_d = 1'b1;
  end

  assign bus.pld_rdy  = rdy;
  assign bus.txd      = txd_q;
  assign bus.tx_en    = en_q;
  assign bus.pac_stp  = stp_q;
  assign pac_num      = num_q;
  assign frame_done   = done_q;
  assign underrun_err = under_q;
  assign ovp_abort    = abort_q;

endmodule
